dmem_access_ctrl: RTL

Sequencing controller for the MEM-stage data-memory port. It accepts one load or store from the pipeline and computes the byte mask and aligned word address. It shifts store data into byte lanes, issues the request, and holds the pipeline stalled until `dmem_resp`. It then returns the aligned, sign- or zero-extended load result together with a one-cycle completion pulse.

---
 rtl/dmem_access_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: one load/store per request, byte-lane
// steering on the way out, load extension on the way back, single-cycle done.
module dmem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_mbe,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [31:0] load_result,
  output logic        done,
  output logic        stall,
  output logic        fault
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned MASKW = XLEN / 8;

  typedef logic [XLEN-1:0]  rv32i_word;
  typedef logic [MASKW-1:0] rv32i_mem_wmask;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e         state_q;
  logic [2:0]     funct3_q;
  logic [1:0]     off_q;
  logic           is_load_q;
  rv32i_word      address_q, wdata_q, result_q;
  rv32i_mem_wmask mbe_q;
  logic           read_q, write_q, done_q, fault_q;

  logic           req_ok_c;
  rv32i_mem_wmask mask_d;
  rv32i_word      wdata_d, ext_d;
  logic           fault_d;
  logic [7:0]     byte_c;
  logic [15:0]    half_c;

  assign req_ok_c     = req_valid & (req_load ^ req_store);
  assign stall        = req_ok_c & (state_q != DONE);
  assign dmem_address = address_q;
  assign dmem_read    = read_q;
  assign dmem_write   = write_q;
  assign dmem_mbe     = mbe_q;
  assign dmem_wdata   = wdata_q;
  assign load_result  = result_q;
  assign done         = done_q;
  assign fault        = fault_q;

  // Request decode: byte enables, lane-shifted store data, legality.
  always_comb begin
    mask_d  = '0;
    wdata_d = '0;
    fault_d = 1'b0;
    case (funct3)
      3'b000, 3'b100: mask_d = 4'b0001 << addr[1:0];
      3'b001, 3'b101: mask_d = addr[1] ? 4'b1100 : 4'b0011;
      3'b010:         mask_d = 4'b1111;
      default:        mask_d = '0;
    endcase
    if (req_store) begin
      case (funct3)
        3'b000:  wdata_d = XLEN'(store_data[7:0]) << {addr[1:0], 3'b000};
        3'b001:  wdata_d = XLEN'(store_data[15:0]) << {addr[1], 4'b0000};
        3'b010:  wdata_d = store_data;
        default: wdata_d = '0;
      endcase
    end
    fault_d = (((funct3 == 3'b001) || (funct3 == 3'b101)) && addr[0])
            || ((funct3 == 3'b010) && (addr[1:0] != 2'b00))
            || (req_load && (funct3 inside {3'b011, 3'b110, 3'b111}))
            || (req_store && !(funct3 inside {3'b000, 3'b001, 3'b010}));
  end

  // Load extraction from the latched offset and width.
  always_comb begin
    byte_c = 8'(dmem_rdata >> {off_q, 3'b000});
    half_c = 16'(dmem_rdata >> {off_q[1], 4'b0000});
    case (funct3_q)
      3'b000:  ext_d = {{24{byte_c[7]}}, byte_c};
      3'b100:  ext_d = {24'b0, byte_c};
      3'b001:  ext_d = {{16{half_c[15]}}, half_c};
      3'b101:  ext_d = {16'b0, half_c};
      3'b010:  ext_d = dmem_rdata;
      default: ext_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      funct3_q  <= '0;
      off_q     <= '0;
      is_load_q <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
      result_q  <= '0;
      mbe_q     <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q   <= 1'b0;
          fault_q  <= 1'b0;
          result_q <= '0;
          if (req_ok_c) begin
            if (fault_d) begin
              // Illegal access completes without touching memory.
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              state_q <= DONE;
            end else begin
              funct3_q  <= funct3;
              off_q     <= addr[1:0];
              is_load_q <= req_load;
              address_q <= {addr[31:2], 2'b00};
              mbe_q     <= mask_d;
              wdata_q   <= wdata_d;
              read_q    <= req_load;
              write_q   <= req_store;
              state_q   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            done_q   <= 1'b1;
            result_q <= is_load_q ? ext_d : '0;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q   <= 1'b0;
          fault_q  <= 1'b0;
          result_q <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
